// File: rtl/multiplier_arbiter_module.sv
// -----------------------------------------------------------------------------
// multiplier_arbiter_module
//
// Purpose:
//   Shares one signed 8x8 multiplier among NUM_REQ requesters using a
//   round-robin arbiter. Each requester uses the same start/done level
//   handshake the multiplier uses. The arbiter latches the granted
//   requester's operands, sequences the multiplier and returns the 16-bit
//   product together with a one-cycle done pulse to the served requester.
//
// Optional feature:
//   Define MULT_ARB_TIMEOUT_EN to enable the RUN-state watchdog. When it is
//   enabled, a stuck multiplier is abandoned after TIMEOUT_CYCLES cycles in
//   RUN. The requester then receives a done pulse with a zero product, and
//   timeout_err is set and stays set until reset. When the macro is
//   undefined, RUN waits indefinitely and timeout_err is tied low.
//
// Parameters:
//   NUM_REQ          number of requesters (2..8)
//   ID_W             grant index width, equal to clog2(NUM_REQ)
//   TIMEOUT_CYCLES   RUN-state cycle limit (used with MULT_ARB_TIMEOUT_EN)
//
// Ports:
//   clk               in   rising-edge system clock
//   rst_n             in   asynchronous active-low reset
//   req_start_sig     in   per-requester request level, held until own done
//   req_multiplicand  in   packed signed operands, slice i = [8i+7:8i]
//   req_multiplier    in   packed signed operands, slice i = [8i+7:8i]
//   req_done_sig      out  one-cycle done pulse to the served requester
//   req_product       out  signed product, valid while req_done_sig is high
//   busy              out  high from grant through the RELEASE cycle
//   grant_id          out  index of the current or last served requester
//   timeout_err       out  sticky timeout flag
//   mult_start_sig    out  start level to the multiplier
//   mult_multiplicand out  operand to the multiplier, stable while started
//   mult_multiplier   out  operand to the multiplier, stable while started
//   mult_done_sig     in   done level from the multiplier
//   mult_product      in   product from the multiplier, sampled on done
// -----------------------------------------------------------------------------
module multiplier_arbiter_module #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_start_sig,
    input  logic [NUM_REQ*8-1:0]   req_multiplicand,
    input  logic [NUM_REQ*8-1:0]   req_multiplier,
    output logic [NUM_REQ-1:0]     req_done_sig,
    output logic [15:0]            req_product,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   timeout_err,
    output logic                   mult_start_sig,
    output logic [7:0]             mult_multiplicand,
    output logic [7:0]             mult_multiplier,
    input  logic                   mult_done_sig,
    input  logic [15:0]            mult_product
);

    // Reject parameter sets the arbiter cannot represent at elaboration time,
    // so that a wrong ID_W cannot silently alias requesters.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) ||
            TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("multiplier_arbiter_module: unsupported parameter set");
        end
    endgenerate

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic                   busy_q, busy_d;
    logic                   mult_start_q, mult_start_d;
    logic [7:0]             mult_mcand_q, mult_mcand_d;
    logic [7:0]             mult_mplier_q, mult_mplier_d;
    logic [NUM_REQ-1:0]     req_done_q, req_done_d;
    logic [15:0]            req_product_q, req_product_d;

    logic [2*NUM_REQ-1:0]   req_dbl;
    logic [NUM_REQ-1:0]     req_rot;
    logic                   win_found;
    logic [ID_W-1:0]        win_off;
    logic [ID_W:0]          idx_sum;
    logic [ID_W-1:0]        win_idx;
    logic [NUM_REQ-1:0]     grant_onehot;

`ifdef MULT_ARB_TIMEOUT_EN
    // Counter is at least 8 bits wide and wide enough to hold the limit.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]       to_cnt_q, to_cnt_d;
    logic                   timeout_err_q, timeout_err_d;
`endif

    // Round-robin winner search. The request vector is duplicated and
    // rotated right by the pointer, so bit k of req_rot is requester
    // (ptr + k) mod NUM_REQ. The lowest set bit of req_rot is the winner,
    // which gives priority starting at the pointer and wrapping upward.
    // The loop runs downward so that the lowest offset is written last.
    always_comb begin
        req_dbl   = {req_start_sig, req_start_sig};
        req_rot   = NUM_REQ'(req_dbl >> ptr_q);
        win_found = 1'b0;
        win_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_off   = ID_W'(k);
            end
        end
        idx_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (idx_sum >= NUM_REQ_W) begin
            idx_sum = idx_sum - NUM_REQ_W;
        end
        win_idx = ID_W'(idx_sum);
    end

    // One-hot form of the current grant, used to steer the done pulse.
    always_comb begin
        grant_onehot = NUM_REQ'(1) << grant_id_q;
    end

    // Next-state and datapath logic for the IDLE -> RUN -> RELEASE loop.
    // Every register holds its value by default. The done pulse defaults
    // to low, so it stays high only for the single RELEASE cycle.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        mult_start_d  = mult_start_q;
        mult_mcand_d  = mult_mcand_q;
        mult_mplier_d = mult_mplier_q;
        req_done_d    = '0;
        req_product_d = req_product_q;
`ifdef MULT_ARB_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (win_found) begin
                    // Grant and start the multiplier on the same edge. The
                    // operands are frozen here and later requester changes
                    // do not reach the multiplier.
                    grant_id_d    = win_idx;
                    busy_d        = 1'b1;
                    mult_start_d  = 1'b1;
                    mult_mcand_d  = req_multiplicand[{win_idx, 3'b000} +: 8];
                    mult_mplier_d = req_multiplier[{win_idx, 3'b000} +: 8];
                    ptr_d         = (win_idx == LAST_IDX) ? '0 : win_idx + ID_W'(1);
                    state_d       = ST_RUN;
`ifdef MULT_ARB_TIMEOUT_EN
                    to_cnt_d      = '0;
`endif
                end
            end

            ST_RUN: begin
                if (mult_done_sig) begin
                    req_product_d = mult_product;
                    req_done_d    = grant_onehot;
                    mult_start_d  = 1'b0;
                    state_d       = ST_RELEASE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    // This is the TIMEOUT_CYCLES-th RUN edge without a done.
                    // Abandon the operation and report a zero product.
                    req_product_d = 16'h0000;
                    req_done_d    = grant_onehot;
                    mult_start_d  = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_RELEASE;
                end else begin
                    to_cnt_d      = to_cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_RELEASE: begin
                // The multiplier sees start low for this cycle and returns
                // to idle. The requester drops its request at this edge.
                mult_start_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end

            default: begin
                mult_start_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset is asynchronous, so that a reset
    // during RUN drops mult_start_sig at once and discards the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            mult_start_q  <= 1'b0;
            mult_mcand_q  <= '0;
            mult_mplier_q <= '0;
            req_done_q    <= '0;
            req_product_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            mult_start_q  <= mult_start_d;
            mult_mcand_q  <= mult_mcand_d;
            mult_mplier_q <= mult_mplier_d;
            req_done_q    <= req_done_d;
            req_product_q <= req_product_d;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag. Only a reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // All outputs come straight from registers.
    assign req_done_sig      = req_done_q;
    assign req_product       = req_product_q;
    assign busy              = busy_q;
    assign grant_id          = grant_id_q;
    assign mult_start_sig    = mult_start_q;
    assign mult_multiplicand = mult_mcand_q;
    assign mult_multiplier   = mult_mplier_q;

endmodule
